// File: rtl/matmult_stream_feeder.sv
// Stream feeder for the sequential 4x4 matrix x vector dot-product engine.
// Latches operands on start, streams (a,b) beats row by row, captures per-row results.

module feeder_row_result #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    q <= '0;
    else if (clr)  q <= '0;
    else if (load) q <= d;
  end
endmodule

module matmult_stream_feeder #(
  parameter int DATA_W = 16,
  parameter int GAP    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [16*DATA_W-1:0] mat_in,
  input  logic [4*DATA_W-1:0]  vec_in,
  output logic [31:0]          a,
  output logic [31:0]          b,
  output logic                 a_tvalid,
  output logic                 b_tvalid,
  input  logic                 tready,
  input  logic                 dot_valid,
  input  logic [31:0]          dot_result,
  output logic [31:0]          result0,
  output logic [31:0]          result1,
  output logic [31:0]          result2,
  output logic [31:0]          result3,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_GAP, S_WAIT_ROW, S_DONE} state_t;

  localparam bit         HAS_GAP  = (GAP > 0);
  localparam logic [3:0] GAP_LAST = HAS_GAP ? 4'(GAP - 1) : 4'd0;

  state_t                   state, state_nxt;
  logic [15:0][DATA_W-1:0]  mat_q;
  logic [3:0][DATA_W-1:0]   vec_q;
  logic [1:0]               row, col;
  logic [3:0]               gap_cnt;
  logic [3:0][31:0]         res;
  logic                     accept, xfer, capture;

  assign accept  = (state == S_IDLE) && start;
  assign xfer    = (state == S_SEND) && tready;
  assign capture = (state == S_WAIT_ROW) && dot_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_SEND;
      S_SEND:     if (tready) begin
                    if (col == 2'd3) state_nxt = S_WAIT_ROW;
                    else             state_nxt = HAS_GAP ? S_GAP : S_SEND;
                  end
      S_GAP:      if (gap_cnt == GAP_LAST) state_nxt = S_SEND;
      S_WAIT_ROW: if (dot_valid) begin
                    if (row == 2'd3) state_nxt = S_DONE;
                    else             state_nxt = HAS_GAP ? S_GAP : S_SEND;
                  end
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Operands are latched so the upstream may change mat_in/vec_in mid-run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mat_q   <= '0;
      vec_q   <= '0;
      row     <= '0;
      col     <= '0;
      gap_cnt <= '0;
    end else begin
      if (accept) begin
        mat_q <= mat_in;
        vec_q <= vec_in;
        row   <= '0;
        col   <= '0;
      end
      if (xfer && col != 2'd3) begin
        col     <= col + 2'd1;
        gap_cnt <= '0;
      end
      if (state == S_GAP) gap_cnt <= gap_cnt + 4'd1;
      if (capture && row != 2'd3) begin
        row     <= row + 2'd1;
        col     <= '0;
        gap_cnt <= '0;
      end
    end
  end

  for (genvar r = 0; r < 4; r++) begin : g_res
    feeder_row_result #(.W(32)) u_res (
      .clk  (clk),
      .reset(reset),
      .clr  (accept),
      .load (capture && row == 2'(r)),
      .d    (dot_result),
      .q    (res[r])
    );
  end

  assign result0  = res[0];
  assign result1  = res[1];
  assign result2  = res[2];
  assign result3  = res[3];

  // During GAP the mux already shows the next element; harmless since tvalid is low.
  assign a        = 32'(mat_q[{row, col}]);
  assign b        = 32'(vec_q[col]);
  assign a_tvalid = (state == S_SEND);
  assign b_tvalid = (state == S_SEND);
  assign busy     = (state == S_SEND) || (state == S_GAP) || (state == S_WAIT_ROW);
  assign done     = (state == S_DONE);
endmodule

// File: tb/tb_matmult_stream_feeder.sv
// Bench for matmult_stream_feeder: scenario table, random runs against a
// dot-product reference, mid-run reset, and a GAP=0 instance.

module tb_matmult_stream_feeder;
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [255:0]  mat_in = '0;
  logic [63:0]   vec_in = '0;

  logic          start0 = 1'b0, tready0 = 1'b1, force_dv = 1'b0;
  logic [31:0]   a0, b0, r00, r01, r02, r03;
  logic          av0, bv0, busy0, done0, dv0, eng_dv0;
  logic [31:0]   eng_res0 = '0, acc0 = '0;

  logic          start1 = 1'b0;
  logic [31:0]   a1, b1, r10, r11, r12, r13;
  logic          av1, bv1, busy1, done1, eng_dv1;
  logic [31:0]   eng_res1 = '0, acc1 = '0;

  int            cyc = 0, t0 = 0, eng_dly = 1;
  int            n0 = 0, wt0 = 0, n1 = 0;
  int            n_checks = 0, n_fail = 0;
  logic [63:0]   obs0[$], obs1[$];
  int            beatk0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign dv0 = eng_dv0 | force_dv;

  matmult_stream_feeder #(.DATA_W(16), .GAP(1)) u0 (
    .clk(clk), .reset(reset), .start(start0), .mat_in(mat_in), .vec_in(vec_in),
    .a(a0), .b(b0), .a_tvalid(av0), .b_tvalid(bv0), .tready(tready0),
    .dot_valid(dv0), .dot_result(eng_res0),
    .result0(r00), .result1(r01), .result2(r02), .result3(r03),
    .busy(busy0), .done(done0)
  );

  matmult_stream_feeder #(.DATA_W(16), .GAP(0)) u1 (
    .clk(clk), .reset(reset), .start(start1), .mat_in(mat_in), .vec_in(vec_in),
    .a(a1), .b(b1), .a_tvalid(av1), .b_tvalid(bv1), .tready(1'b1),
    .dot_valid(eng_dv1), .dot_result(eng_res1),
    .result0(r10), .result1(r11), .result2(r12), .result3(r13),
    .busy(busy1), .done(done1)
  );

  // Behavioural engines: accumulate 4 beats, return the row sum after eng_dly cycles.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng_dv0 <= 1'b0; acc0 <= '0; n0 <= 0; wt0 <= 0;
    end else begin
      eng_dv0 <= 1'b0;
      if (wt0 == 1) eng_dv0 <= 1'b1;
      if (wt0 > 0) wt0 <= wt0 - 1;
      if (av0 && tready0) begin
        obs0.push_back({a0, b0});
        beatk0.push_back(cyc - t0);
        if (n0 == 3) begin
          eng_res0 <= acc0 + a0 * b0; acc0 <= '0; n0 <= 0;
          if (eng_dly == 1) eng_dv0 <= 1'b1; else wt0 <= eng_dly - 1;
        end else begin
          acc0 <= acc0 + a0 * b0; n0 <= n0 + 1;
        end
      end
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng_dv1 <= 1'b0; acc1 <= '0; n1 <= 0;
    end else begin
      eng_dv1 <= 1'b0;
      if (av1) begin
        obs1.push_back({a1, b1});
        if (n1 == 3) begin
          eng_res1 <= acc1 + a1 * b1; acc1 <= '0; n1 <= 0; eng_dv1 <= 1'b1;
        end else begin
          acc1 <= acc1 + a1 * b1; n1 <= n1 + 1;
        end
      end
    end
  end

  typedef struct {
    logic [255:0]     m;
    logic [63:0]      v;
    int               stall_lo, stall_len, spur_start, spur_dv, exp_done;
    logic [3:0][31:0] exp_r;
    string            tag;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] el(input logic [255:0] m, input int idx);
    return m[idx*16 +: 16];
  endfunction

  // Reference: each row result is the plain 32-bit dot product of that row with V.
  function automatic logic [3:0][31:0] ref_dot(input logic [255:0] m, input logic [63:0] v);
    logic [3:0][31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i] = '0;
      for (int j = 0; j < 4; j++) r[i] += 32'(el(m, 4*i+j)) * 32'(v[j*16 +: 16]);
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [255:0] m, input logic [63:0] v, input int slo, slen,
                              sst, sdv, edone, input logic [3:0][31:0] er, input string tag);
    vec_t t;
    t.m = m; t.v = v; t.stall_lo = slo; t.stall_len = slen; t.spur_start = sst;
    t.spur_dv = sdv; t.exp_done = edone; t.exp_r = er; t.tag = tag;
    return t;
  endfunction

  task automatic run0(input vec_t tv, input bit rnd, input int dly, input int reset_k);
    logic [63:0] exq[$];
    logic [31:0] pa, pb;
    logic        pv, pr;
    int          done_k, ndone, busy_bad, tvb_bad, tim_bad;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exq.push_back({32'(el(tv.m, 4*r+c)), 32'(tv.v[c*16 +: 16])});
    obs0.delete(); beatk0.delete(); eng_dly = dly;
    done_k = -1; ndone = 0; busy_bad = 0; tvb_bad = 0; pv = 1'b0; pr = 1'b1; pa = '0; pb = '0;
    @(negedge clk);
    mat_in = tv.m; vec_in = tv.v; start0 = 1'b1; tready0 = 1'b1; t0 = cyc;
    for (int k = 1; k < 400; k++) begin
      @(negedge clk);
      start0 = (k == tv.spur_start);
      force_dv = (k == tv.spur_dv);
      mat_in = {8{$urandom()}}; vec_in = {$urandom(), $urandom()};
      if (k == 1) chk({tv.tag, " first_beat"}, {a0, b0, 31'd0, av0},
                      {32'(el(tv.m, 0)), 32'(tv.v[15:0]), 31'd0, 1'b1});
      if (pv && !pr) chk({tv.tag, " stall_hold"}, {a0, b0, 31'd0, av0}, {pa, pb, 31'd0, 1'b1});
      if (!rnd && tv.stall_len > 0 && k == tv.stall_lo)
        chk({tv.tag, " stall_beat"}, {a0, b0}, {32'(el(tv.m, 5)), 32'(tv.v[31:16])});
      if (av0 !== bv0) tvb_bad++;
      if (tv.exp_done > 0 && busy0 !== (k < tv.exp_done)) busy_bad++;
      if (done0) begin ndone++; done_k = k; end
      if (k == reset_k) begin
        chk("pre_reset", {r00, r01, busy0}, {tv.exp_r[0], tv.exp_r[1], 1'b1});
        reset = 1'b0;
        #1;
        chk("reset_async", {av0, bv0, busy0, done0, a0, b0}, '0);
        chk("reset_results", {r00, r01, r02, r03}, '0);
        start0 = 1'b0; force_dv = 1'b0; tready0 = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      tready0 = rnd ? ($urandom_range(0, 9) < 7)
                    : !(k >= tv.stall_lo && k < tv.stall_lo + tv.stall_len);
      pv = av0; pr = tready0; pa = a0; pb = b0;
      if (done_k > 0 && k >= done_k + 3) break;
    end
    start0 = 1'b0; force_dv = 1'b0; tready0 = 1'b1;
    chk({tv.tag, " done_pulses"}, 64'(ndone), 64'd1);
    if (tv.exp_done > 0) begin
      chk({tv.tag, " done_cycle"}, 64'(done_k), 64'(tv.exp_done));
      chk({tv.tag, " busy_window"}, 64'(busy_bad), 64'd0);
    end
    chk({tv.tag, " tvalid_pair"}, 64'(tvb_bad), 64'd0);
    chk({tv.tag, " result0"}, 64'(r00), 64'(tv.exp_r[0]));
    chk({tv.tag, " result1"}, 64'(r01), 64'(tv.exp_r[1]));
    chk({tv.tag, " result2"}, 64'(r02), 64'(tv.exp_r[2]));
    chk({tv.tag, " result3"}, 64'(r03), 64'(tv.exp_r[3]));
    chk({tv.tag, " beat_count"}, 64'(obs0.size()), 64'd16);
    for (int i = 0; i < 16 && i < obs0.size(); i++)
      if (obs0[i] !== exq[i]) chk({tv.tag, " beat_data"}, obs0[i], exq[i]);
    if (!rnd && tv.stall_len == 0 && dly == 1) begin
      tim_bad = 0;
      for (int i = 0; i < beatk0.size(); i++)
        if (beatk0[i] != 1 + 9*(i/4) + 2*(i%4)) tim_bad++;
      chk({tv.tag, " beat_timing"}, 64'(tim_bad), 64'd0);
    end
  endtask

  task automatic run1(input logic [255:0] m, input logic [63:0] v, input logic [3:0][31:0] er);
    logic [63:0] exq[$];
    int          done_k, ndone, tv_bad;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exq.push_back({32'(el(m, 4*r+c)), 32'(v[c*16 +: 16])});
    obs1.delete(); done_k = -1; ndone = 0; tv_bad = 0;
    @(negedge clk);
    mat_in = m; vec_in = v; start1 = 1'b1; t0 = cyc;
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      mat_in = {8{$urandom()}};
      // Four back-to-back beats per row, one WAIT_ROW cycle between rows.
      if (av1 !== (k >= 1 && k <= 20 && (k % 5) != 0)) tv_bad++;
      if (done1) begin ndone++; done_k = k; end
      if (done_k > 0 && k >= done_k + 3) break;
    end
    chk("gap0 tvalid_pattern", 64'(tv_bad), 64'd0);
    chk("gap0 done_cycle", {32'(done_k), 32'(ndone)}, {32'd21, 32'd1});
    chk("gap0 results", {r10, r11, r12, r13}, {er[0], er[1], er[2], er[3]});
    chk("gap0 beat_count", 64'(obs1.size()), 64'd16);
    for (int i = 0; i < 16 && i < obs1.size(); i++)
      if (obs1[i] !== exq[i]) chk("gap0 beat_data", obs1[i], exq[i]);
  endtask

  localparam logic [255:0] MF = {16'd5, 16'd3, 16'd5, 16'd4, 16'd2, 16'd3, 16'd2, 16'd1,
                                 16'd3, 16'd7, 16'd6, 16'd5, 16'd3, 16'd2, 16'd1, 16'd1};
  localparam logic [63:0]  VF = {16'd1, 16'd3, 16'd5, 16'd2};

  initial begin
    logic [3:0][31:0] efun, effff;
    vec_t             rv;
    efun  = {32'd47, 32'd23, 32'd64, 32'd16};
    effff = {4{32'hFFF80004}};
    tbl[0] = mk(MF, VF, 0, 0, -1, -1, 36, efun, "func");
    tbl[1] = mk(MF, VF, 12, 3, -1, -1, 39, efun, "stall");
    tbl[2] = mk(MF, VF, 0, 0, 5, 3, 36, efun, "robust");
    tbl[3] = mk({16{16'hFFFF}}, {4{16'hFFFF}}, 0, 0, -1, -1, 36, effff, "zext");

    repeat (3) @(negedge clk);
    #1;
    chk("reset_state", {a0, b0, av0, bv0, busy0, done0}, '0);
    chk("reset_results", {r00, r01, r02, r03}, '0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) run0(tbl[i], 1'b0, 1, -1);

    run0(tbl[0], 1'b0, 1, 26);
    run0(tbl[0], 1'b0, 1, -1);

    for (int i = 0; i < 4; i++) begin
      logic [255:0] m;
      logic [63:0]  v;
      m = {8{$urandom()}};
      for (int j = 0; j < 8; j++) m[j*32 +: 32] = $urandom();
      v = {$urandom(), $urandom()};
      rv = mk(m, v, 0, 0, -1, -1, -1, ref_dot(m, v), "rand");
      run0(rv, 1'b1, $urandom_range(1, 3), -1);
    end

    run1(MF, VF, efun);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/matmult_stream_feeder.md
Name: matmult_stream_feeder

Overview:
- Initiator for the sequential 4x4 matrix x 4-vector dot-product engine (matrixmultiplier).
- Latches one matrix and one vector on start, then streams (a, b) element pairs row by row over the a/b/tvalid interface.
- After each row's 4 beats, waits for the engine's per-row dot-product result and captures it.
- Pulses done once all 4 row results are captured; replaces hand-written stimulus sequences in system use.

Parameters:
- DATA_W, 16: width of each matrix/vector element; zero-extended to 32 bits on a/b.
- GAP, 1: idle cycles with tvalid low after each accepted beat; legal range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- mat_in  in  16*DATA_W  row-major matrix; element (r,c) at bits [(4r+c)*DATA_W +: DATA_W].
- vec_in  in  4*DATA_W  vector; element c at bits [c*DATA_W +: DATA_W].
- a  out  32  matrix element for the current beat, zero-extended.
- b  out  32  vector element for the current beat, zero-extended.
- a_tvalid  out  1  beat valid.
- b_tvalid  out  1  beat valid; always equal to a_tvalid.
- tready  in  1  engine accepts the beat; tie high for engines with no backpressure.
- dot_valid  in  1  engine row-result strobe (done_matrixmult).
- dot_result  in  32  engine row result.
- result0..result3  out  32 each  captured row results.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse when all 4 results are captured.

Behaviour:
- Reset (asynchronous, immediate, including mid-operation): state=IDLE, a=b=0, tvalid=0, result0..3=0, busy=0, done=0, row/col/gap counters=0.
- States: IDLE, SEND, GAP, WAIT_ROW, DONE.
- IDLE:
  - start=1 latches mat_in/vec_in, clears result0..3, sets row=col=0, goes to SEND.
  - Next cycle: tvalid=1, a=M[0][0], b=V[0], busy=1.
- SEND:
  - tvalid=1; a/b hold stable until tvalid&&tready.
  - On transfer with col<3: col++; goes to GAP if GAP>0, else stays in SEND with the next element presented the following cycle.
  - On transfer with col=3: goes to WAIT_ROW, tvalid=0.
- GAP: tvalid=0 for exactly GAP cycles, then SEND with the next element. a/b may already show the next element.
- WAIT_ROW:
  - tvalid=0; on dot_valid, result[row]<=dot_result.
  - If row<3: row++, col=0, goes to GAP (GAP>0) or SEND.
  - If row=3: goes to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Ignored inputs:
  - start while busy is ignored.
  - dot_valid outside WAIT_ROW is ignored.
- Simultaneous start and done: start in the DONE cycle is ignored. start is accepted in IDLE only.
- Results hold until the next accepted start or reset.
- Latency with tready=1, GAP=1 and dot_valid returned 1 cycle after the last beat of each row:
  - start at cycle 0.
  - Row r beats at cycles 1+9r, 3+9r, 5+9r, 7+9r.
  - dot_valid for row r at cycle 8+9r.
  - done at cycle 36.
- Arithmetic: no arithmetic on data; zero-extension only; DATA_W>32 is illegal.

Test Plan:
- Functional run: M = [1,1,2,3; 5,6,7,3; 1,2,3,2; 4,5,3,5], V = [2,5,3,1], tready=1, GAP=1, behavioural engine model -> beat sequence (1,2),(1,5),(2,3),(3,1),(5,2),...; result0..3 = 16, 64, 23, 47; done pulses at cycle 36; busy high for cycles 1-35.
- Backpressure: same data, tready low for 3 cycles on beat (1,1) -> a=6, b=5 held stable with tvalid high throughout the stall; final results unchanged; done delayed by exactly 3 cycles.
- Back-to-back beats: GAP=0, tready=1 -> 4 consecutive valid beats per row; tvalid drops only in WAIT_ROW; results 16, 64, 23, 47.
- Protocol robustness: start pulsed while busy, and dot_valid pulsed during SEND -> both ignored; beat order and results unchanged.
- Reset mid-run: reset asserted during row 2 WAIT_ROW -> tvalid, busy and result0..3 go 0 immediately without a clock edge; a new start after release produces the full correct sequence from M[0][0].
- Zero-extension: DATA_W=16, elements 16'hFFFF -> a = b = 32'h0000FFFF.
